// File: rtl/iob_ext_mem_arbiter.sv
// Shares one IOb external-memory port among N_MASTERS masters, one access at a time.
// Round-robin by default; define IOB_EXT_MEM_ARBITER_FIXED_PRIO_EN for lowest-index priority.
module iob_ext_mem_arbiter #(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
) (
    input  logic                            clk_i,
    input  logic                            arst_n_i,
    input  logic                            cke_i,
    input  logic [N_MASTERS-1:0]            m_avalid_i,
    input  logic [N_MASTERS*ADDR_W-1:0]     m_addr_i,
    input  logic [N_MASTERS*DATA_W-1:0]     m_wdata_i,
    input  logic [N_MASTERS*DATA_W/8-1:0]   m_wstrb_i,
    output logic [N_MASTERS-1:0]            m_ready_o,
    output logic [N_MASTERS-1:0]            m_rvalid_o,
    output logic [N_MASTERS*DATA_W-1:0]     m_rdata_o,
    output logic                            s_avalid_o,
    output logic [ADDR_W-1:0]               s_addr_o,
    output logic [DATA_W-1:0]               s_wdata_o,
    output logic [DATA_W/8-1:0]             s_wstrb_o,
    input  logic                            s_ready_i,
    input  logic                            s_rvalid_i,
    input  logic [DATA_W-1:0]               s_rdata_i,
    output logic [N_MASTERS-1:0]            grant_o,
    output logic                            busy_o
);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RDATA
    } state_t;

    state_t                 state;
    logic [N_MASTERS-1:0]   grant;
    logic [N_MASTERS-1:0]   next_grant;
    logic                   g_avalid;
    logic [ADDR_W-1:0]      mux_addr;
    logic [DATA_W-1:0]      mux_wdata;
    logic [STRB_W-1:0]      mux_wstrb;
    logic                   in_access;
    logic                   accept;

    always_comb begin
        g_avalid  = 1'b0;
        mux_addr  = '0;
        mux_wdata = '0;
        mux_wstrb = '0;
        for (int k = 0; k < N_MASTERS; k++) begin
            if (grant[k]) begin
                g_avalid  = m_avalid_i[k];
                mux_addr  = m_addr_i[k*ADDR_W +: ADDR_W];
                mux_wdata = m_wdata_i[k*DATA_W +: DATA_W];
                mux_wstrb = m_wstrb_i[k*STRB_W +: STRB_W];
            end
        end
    end

    assign in_access = (state == ACCESS);
    assign accept    = in_access & g_avalid & s_ready_i;

`ifdef IOB_EXT_MEM_ARBITER_FIXED_PRIO_EN
    always_comb begin
        next_grant = '0;
        for (int k = N_MASTERS - 1; k >= 0; k--) begin
            if (m_avalid_i[k]) begin
                next_grant    = '0;
                next_grant[k] = 1'b1;
            end
        end
    end
`else
    localparam int IDX_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

    logic [IDX_W-1:0]       last_idx;
    logic [IDX_W-1:0]       g_idx;
    logic [N_MASTERS-1:0]   hi_grant;
    logic [N_MASTERS-1:0]   lo_grant;

    // Lowest requester above last_idx wins; otherwise wrap to the lowest overall.
    always_comb begin
        hi_grant = '0;
        lo_grant = '0;
        g_idx    = '0;
        for (int k = N_MASTERS - 1; k >= 0; k--) begin
            if (m_avalid_i[k]) begin
                lo_grant    = '0;
                lo_grant[k] = 1'b1;
                if (IDX_W'(k) > last_idx) begin
                    hi_grant    = '0;
                    hi_grant[k] = 1'b1;
                end
            end
            if (grant[k]) g_idx = IDX_W'(k);
        end
        next_grant = (|hi_grant) ? hi_grant : lo_grant;
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            last_idx <= IDX_W'(N_MASTERS - 1);
        end else if (cke_i && accept) begin
            last_idx <= g_idx;
        end
    end
`endif

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state <= IDLE;
            grant <= '0;
        end else if (cke_i) begin
            case (state)
                IDLE: begin
                    if (|m_avalid_i) begin
                        grant <= next_grant;
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    // A master withdrawing its request releases the port unserved.
                    if (!g_avalid || (s_ready_i && (|mux_wstrb))) begin
                        state <= IDLE;
                        grant <= '0;
                    end else if (s_ready_i) begin
                        state <= RDATA;
                    end
                end
                RDATA: begin
                    if (s_rvalid_i) begin
                        state <= IDLE;
                        grant <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

    assign s_avalid_o = in_access & g_avalid;
    assign s_addr_o   = in_access ? mux_addr : '0;
    assign s_wdata_o  = in_access ? mux_wdata : '0;
    assign s_wstrb_o  = in_access ? mux_wstrb : '0;
    assign m_ready_o  = in_access ? (grant & {N_MASTERS{s_ready_i}}) : '0;
    assign m_rvalid_o = (state == RDATA) ? (grant & {N_MASTERS{s_rvalid_i}}) : '0;
    assign m_rdata_o  = {N_MASTERS{s_rdata_i}};
    assign grant_o    = grant;
    assign busy_o     = (state != IDLE);

endmodule

// File: tb/tb_iob_ext_mem_arbiter.sv
// Testbench for iob_ext_mem_arbiter with N_MASTERS=2.
// Grant and read-data expectations flow through scoreboard queues.
module tb_iob_ext_mem_arbiter;
    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    typedef struct {
        logic [N-1:0]  mask;
        logic [DW-1:0] data;
    } rd_t;

    logic            clk = 1'b0;
    logic            arst_n = 1'b0;
    logic            cke;
    logic [N-1:0]    m_avalid;
    logic [N*AW-1:0] m_addr;
    logic [N*DW-1:0] m_wdata;
    logic [N*SW-1:0] m_wstrb;
    logic [N-1:0]    m_ready;
    logic [N-1:0]    m_rvalid;
    logic [N*DW-1:0] m_rdata;
    logic            s_avalid;
    logic [AW-1:0]   s_addr;
    logic [DW-1:0]   s_wdata;
    logic [SW-1:0]   s_wstrb;
    logic            s_ready;
    logic            s_rvalid;
    logic [DW-1:0]   s_rdata;
    logic [N-1:0]    grant;
    logic            busy;

    int checks = 0;
    int errors = 0;
    logic [N-1:0] grant_q[$];
    rd_t          rd_q[$];

    iob_ext_mem_arbiter #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke),
        .m_avalid_i(m_avalid), .m_addr_i(m_addr), .m_wdata_i(m_wdata),
        .m_wstrb_i(m_wstrb), .m_ready_o(m_ready), .m_rvalid_o(m_rvalid),
        .m_rdata_o(m_rdata), .s_avalid_o(s_avalid), .s_addr_o(s_addr),
        .s_wdata_o(s_wdata), .s_wstrb_o(s_wstrb), .s_ready_i(s_ready),
        .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata), .grant_o(grant),
        .busy_o(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        cke      = 1'b1;
        m_avalid = '0;
        m_addr   = '0;
        m_wdata  = '0;
        m_wstrb  = '0;
        s_ready  = 1'b0;
        s_rvalid = 1'b0;
        s_rdata  = '0;
    endtask

    task automatic do_reset();
        step();
        arst_n = 1'b0;
        clear_inputs();
        @(negedge clk);
        step();
        arst_n = 1'b1;
    endtask

    task automatic test_reset();
        arst_n   = 1'b0;
        m_avalid = '1;
        m_addr   = '1;
        m_wdata  = '1;
        m_wstrb  = '1;
        s_ready  = 1'b1;
        s_rvalid = 1'b1;
        s_rdata  = 32'hCAFEF00D;
        @(negedge clk);
        checks++;
        if ({m_ready, m_rvalid, s_avalid} !== '0) begin
            errors++;
            $display("FAIL reset_handshake: got m_ready=%b m_rvalid=%b s_avalid=%b expected all 0",
                     m_ready, m_rvalid, s_avalid);
        end
        checks++;
        if ({s_addr, s_wdata, s_wstrb} !== '0) begin
            errors++;
            $display("FAIL reset_slave_bus: got addr=%h wdata=%h wstrb=%h expected 0",
                     s_addr, s_wdata, s_wstrb);
        end
        checks++;
        if ({grant, busy} !== '0) begin
            errors++;
            $display("FAIL reset_grant_busy: got grant=%b busy=%b expected 0", grant, busy);
        end
        clear_inputs();
        step();
        arst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if ({grant, busy} !== '0) begin
                errors++;
                $display("FAIL idle_after_reset: cycle %0d got grant=%b busy=%b expected 0",
                         i, grant, busy);
            end
            step();
        end
    endtask

    task automatic test_single_read();
        rd_t r;
        do_reset();
        m_avalid = 2'b10;
        m_addr[AW +: AW] = 32'h100;
        s_ready  = 1'b1;
        s_rvalid = 1'b1;
        s_rdata  = 32'h12345678;
        @(negedge clk);
        checks++;
        if ({m_rvalid, grant} !== '0) begin
            errors++;
            $display("FAIL stray_rvalid_idle: got m_rvalid=%b grant=%b expected 0", m_rvalid, grant);
        end
        step();
        s_rvalid = 1'b0;
        @(negedge clk);
        checks++;
        if (grant !== 2'b10 || s_addr !== 32'h100 || m_ready !== 2'b10 || s_avalid !== 1'b1) begin
            errors++;
            $display("FAIL read_grant: got grant=%b addr=%h m_ready=%b expected 10 00000100 10",
                     grant, s_addr, m_ready);
        end
        if (m_ready[1] && m_avalid[1]) rd_q.push_back('{mask: 2'b10, data: 32'hDEADBEEF});
        step();
        m_avalid = '0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (m_rvalid !== 2'b00 || busy !== 1'b1) begin
                errors++;
                $display("FAIL read_wait: got m_rvalid=%b busy=%b expected 00 1", m_rvalid, busy);
            end
            step();
        end
        s_rvalid = 1'b1;
        s_rdata  = 32'hDEADBEEF;
        @(negedge clk);
        checks++;
        if (rd_q.size() == 0) begin
            errors++;
            $display("FAIL read_data: got m_rvalid=%b with no read outstanding", m_rvalid);
        end else begin
            r = rd_q.pop_front();
            if (m_rvalid !== r.mask || m_rdata[DW +: DW] !== r.data) begin
                errors++;
                $display("FAIL read_data: got m_rvalid=%b lane1=%h expected %b %h",
                         m_rvalid, m_rdata[DW +: DW], r.mask, r.data);
            end
        end
        step();
        s_rvalid = 1'b0;
        @(negedge clk);
        checks++;
        if ({grant, busy} !== '0) begin
            errors++;
            $display("FAIL read_done: got grant=%b busy=%b expected 0", grant, busy);
        end
    endtask

    task automatic test_contention();
        logic [N-1:0]  exp;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_data;
        do_reset();
        m_avalid = 2'b11;
        m_wstrb  = '1;
        m_addr   = {32'h20, 32'h10};
        m_wdata  = {32'hB1B1B1B1, 32'hA0A0A0A0};
        s_ready  = 1'b1;
`ifdef IOB_EXT_MEM_ARBITER_FIXED_PRIO_EN
        for (int i = 0; i < 4; i++) begin
            grant_q.push_back(2'b00);
            grant_q.push_back(2'b01);
        end
`else
        for (int i = 0; i < 2; i++) begin
            grant_q.push_back(2'b00);
            grant_q.push_back(2'b01);
            grant_q.push_back(2'b00);
            grant_q.push_back(2'b10);
        end
`endif
        while (grant_q.size() > 0) begin
            @(negedge clk);
            exp = grant_q.pop_front();
            checks++;
            if (grant !== exp) begin
                errors++;
                $display("FAIL contention_grant: got %b expected %b", grant, exp);
            end
            if (exp != '0) begin
                exp_addr = (exp == 2'b01) ? 32'h10 : 32'h20;
                exp_data = (exp == 2'b01) ? 32'hA0A0A0A0 : 32'hB1B1B1B1;
                checks++;
                if (s_addr !== exp_addr || s_wdata !== exp_data || m_ready !== exp) begin
                    errors++;
                    $display("FAIL contention_write: got addr=%h wdata=%h m_ready=%b expected %h %h %b",
                             s_addr, s_wdata, m_ready, exp_addr, exp_data, exp);
                end
            end
            step();
        end
        clear_inputs();
    endtask

    task automatic test_backpressure();
        do_reset();
        m_avalid = 2'b11;
        m_wstrb  = '1;
        step();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (m_ready !== 2'b00 || s_avalid !== 1'b1 || grant !== 2'b01) begin
                errors++;
                $display("FAIL stall: cycle %0d got m_ready=%b s_avalid=%b grant=%b expected 00 1 01",
                         i, m_ready, s_avalid, grant);
            end
            step();
        end
        s_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (m_ready !== 2'b01) begin
            errors++;
            $display("FAIL stall_release: got m_ready=%b expected 01", m_ready);
        end
        step();
        m_avalid = 2'b10;
        @(negedge clk);
        checks++;
        if (grant !== 2'b00) begin
            errors++;
            $display("FAIL stall_idle: got grant=%b expected 00", grant);
        end
        step();
        @(negedge clk);
        checks++;
        if (grant !== 2'b10 || m_ready !== 2'b10) begin
            errors++;
            $display("FAIL stall_next: got grant=%b m_ready=%b expected 10 10", grant, m_ready);
        end
        step();
        clear_inputs();
    endtask

    task automatic test_cke();
        do_reset();
        cke      = 1'b0;
        m_avalid = 2'b01;
        m_wstrb  = '1;
        s_ready  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({grant, busy} !== '0) begin
                errors++;
                $display("FAIL cke_hold: got grant=%b busy=%b expected 0", grant, busy);
            end
            step();
        end
        cke = 1'b1;
        step();
        @(negedge clk);
        checks++;
        if (grant !== 2'b01) begin
            errors++;
            $display("FAIL cke_resume: got grant=%b expected 01", grant);
        end
        step();
        clear_inputs();
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        m_avalid = 2'b01;
        s_ready  = 1'b1;
        step();
        step();
        m_avalid = '0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || grant !== 2'b01) begin
            errors++;
            $display("FAIL midread_rdata: got busy=%b grant=%b expected 1 01", busy, grant);
        end
        arst_n = 1'b0;
        #1;
        checks++;
        if ({grant, busy} !== '0) begin
            errors++;
            $display("FAIL midread_reset: got grant=%b busy=%b expected 0", grant, busy);
        end
        step();
        arst_n   = 1'b1;
        s_rvalid = 1'b1;
        s_rdata  = 32'h55AA55AA;
        @(negedge clk);
        checks++;
        if (m_rvalid !== 2'b00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midread_late_rvalid: got m_rvalid=%b busy=%b expected 00 0", m_rvalid, busy);
        end
        step();
        s_rvalid = 1'b0;
        m_avalid = 2'b11;
        m_wstrb  = '1;
        step();
        @(negedge clk);
        checks++;
        if (grant !== 2'b01) begin
            errors++;
            $display("FAIL midread_next_grant: got %b expected 01", grant);
        end
        step();
        clear_inputs();
    endtask

`ifdef IOB_EXT_MEM_ARBITER_FIXED_PRIO_EN
    task automatic test_fixed_prio();
        do_reset();
        m_avalid = 2'b11;
        m_wstrb  = '1;
        s_ready  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            checks++;
            if (grant !== 2'b01) begin
                errors++;
                $display("FAIL fixed_prio_m0: got %b expected 01", grant);
            end
            step();
        end
        m_avalid = 2'b10;
        step();
        @(negedge clk);
        checks++;
        if (grant !== 2'b10) begin
            errors++;
            $display("FAIL fixed_prio_m1: got %b expected 10", grant);
        end
        step();
        clear_inputs();
    endtask
`endif

    initial begin
        clear_inputs();
        test_reset();
        test_single_read();
        test_contention();
        test_backpressure();
        test_cke();
        test_reset_mid_read();
`ifdef IOB_EXT_MEM_ARBITER_FIXED_PRIO_EN
        test_fixed_prio();
`endif
        checks++;
        if (rd_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d reads outstanding expected 0", rd_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
